// File: rtl/matvec_mult_seq.sv
// Sequential signed fixed-point matrix-vector multiplier, Res = A x B.
// One shared MAC consumes one product per enabled clock.
module matvec_mult_seq #(
  parameter int WIDTH     = 16,
  parameter int nos       = 4,
  parameter int intDigits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             startMult,
  input  logic [WIDTH-1:0] A [0:nos-1][0:nos-1],
  input  logic [WIDTH-1:0] B [0:nos-1],
  output logic [WIDTH-1:0] Res [0:nos-1],
  output logic             endMult,
  output logic             busy
);

  localparam int F  = WIDTH - intDigits;
  localparam int IW = $clog2(nos);
  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + IW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                 state;
  logic signed [WIDTH-1:0] a_cap [0:nos-1][0:nos-1];
  logic signed [WIDTH-1:0] b_cap [0:nos-1];
  logic        [WIDTH-1:0] rowbuf [0:nos-2];
  logic        [IW-1:0]    i;
  logic        [IW-1:0]    j;
  logic signed [AW-1:0]    acc;

  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    sum;
  logic        [WIDTH-1:0] row_val;
  logic                    last_col;
  logic                    last_row;

  always_comb begin
    prod     = PW'(a_cap[i][j]) * PW'(b_cap[j]);
    sum      = acc + AW'(prod);
    row_val  = WIDTH'(sum >>> F);
    last_col = (j == IW'(nos - 1));
    last_row = (i == IW'(nos - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      endMult <= 1'b0;
      busy    <= 1'b0;
      for (int r = 0; r < nos; r++) begin
        Res[r]   <= '0;
        b_cap[r] <= '0;
        for (int c = 0; c < nos; c++)
          a_cap[r][c] <= '0;
      end
      for (int r = 0; r < nos - 1; r++)
        rowbuf[r] <= '0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (startMult) begin
            for (int r = 0; r < nos; r++) begin
              b_cap[r] <= B[r];
              for (int c = 0; c < nos; c++)
                a_cap[r][c] <= A[r][c];
            end
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!last_col) begin
            acc <= sum;
            j   <= j + 1'b1;
          end else begin
            acc <= '0;
            j   <= '0;
            if (!last_row) begin
              rowbuf[i] <= row_val;
              i         <= i + 1'b1;
            end else begin
              // last row bypasses the buffer straight into Res
              for (int r = 0; r < nos - 1; r++)
                Res[r] <= rowbuf[r];
              Res[nos-1] <= row_val;
              endMult    <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          endMult <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
